// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared 7-segment glyph constants (gfedcba, active-high),
//            error-code encodings and frame FSM state type.
// Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

  // Glyph patterns, bit0 = a ... bit6 = g, segment lit = 1
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Sticky error bits
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_GLYPH    = 2'b01;
  localparam logic [1:0] ERR_MULTI_AN = 2'b10;

  // Frame tracking states
  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_DONE = 1'b1
  } frame_state_e;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_glyph_decode
// Purpose  : Combinational decode of an active-high gfedcba pattern into a
//            hex value, flagging blank and unrecognised patterns.
// Revision : 1.0  initial release
// ============================================================================
module seg7_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       is_hex_o,
  output logic       is_blank_o,
  output logic [3:0] value_o
);

  // Pattern lookup; anything not in the table is neither hex nor blank
  always_comb begin
    is_hex_o   = 1'b1;
    is_blank_o = 1'b0;
    value_o    = 4'h0;
    case (seg_i)
      SEG_0:     value_o = 4'h0;
      SEG_1:     value_o = 4'h1;
      SEG_2:     value_o = 4'h2;
      SEG_3:     value_o = 4'h3;
      SEG_4:     value_o = 4'h4;
      SEG_5:     value_o = 4'h5;
      SEG_6:     value_o = 4'h6;
      SEG_7:     value_o = 4'h7;
      SEG_8:     value_o = 4'h8;
      SEG_9:     value_o = 4'h9;
      SEG_A:     value_o = 4'hA;
      SEG_B:     value_o = 4'hB;
      SEG_C:     value_o = 4'hC;
      SEG_D:     value_o = 4'hD;
      SEG_E:     value_o = 4'hE;
      SEG_F:     value_o = 4'hF;
      SEG_BLANK: begin
        is_hex_o   = 1'b0;
        is_blank_o = 1'b1;
      end
      default:   is_hex_o = 1'b0;
    endcase
  end

endmodule : seg7_glyph_decode
`default_nettype wire

// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_capture
// Purpose  : Readback receiver for a multiplexed 7-segment bus. Filters
//            ghosting with a dwell counter, decodes committed glyphs and
//            pulses frame_valid_o once every digit has been captured.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    clr_err_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_valid_o,
  output logic                    frame_valid_o,
  output logic                    error_o,
  output logic [1:0]              err_code_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] AN_LSB  = NUM_DIGITS'(1);

  // Samples are held already normalised to active-high, so the reset value
  // of zero reads as "no anode, no segment" instead of "all anodes on".
  logic [6:0]              s_seg_q;
  logic [NUM_DIGITS-1:0]   s_an_q;
  logic [6:0]              prev_seg_q;
  logic [SEL_W-1:0]        prev_sel_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, hit;
  logic [1:0]              err_q, err_d;
  frame_state_e            state_q, state_d;

  logic [SEL_W-1:0] sel;
  logic             an_one, an_multi, same, commit;
  logic             is_hex, is_blank;
  logic [3:0]       value;

  seg7_glyph_decode u_glyph (
    .seg_i      (s_seg_q),
    .is_hex_o   (is_hex),
    .is_blank_o (is_blank),
    .value_o    (value)
  );

  // Input sampling register with polarity normalisation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q <= '0;
      s_an_q  <= '0;
    end else begin
      s_seg_q <= SEG_ACTIVE_LOW ? ~seg_in : seg_in;
      s_an_q  <= AN_ACTIVE_LOW  ? ~an_in  : an_in;
    end
  end

  // Anode classification: one-hot, blanking (none) or overlap (several)
  always_comb begin
    an_one   = (s_an_q != '0) && ((s_an_q & (s_an_q - AN_LSB)) == '0);
    an_multi = (s_an_q != '0) && !an_one;
    sel      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_an_q[i]) sel = SEL_W'(i);
    end
  end

  // Dwell counter: restart on any change, saturate at the threshold; a commit
  // fires only on the cycle the threshold is first reached
  always_comb begin
    same  = (sel == prev_sel_q) && (s_seg_q == prev_seg_q);
    cnt_d = '0;
    if (an_one) begin
      if (!same)                 cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      else                       cnt_d = cnt_q;
    end
    commit = an_one && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  // Commit actions, frame tracking and sticky error next-state
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    hit      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit && (sel == SEL_W'(i))) begin
        if (is_hex) begin
          digits_d[4*i +: 4] = value;
          valid_d[i]         = 1'b1;
          hit[i]             = 1'b1;
        end else if (is_blank) begin
          digits_d[4*i +: 4] = 4'h0;
          valid_d[i]         = 1'b0;
          hit[i]             = 1'b1;
        end
      end
    end

    seen_d  = seen_q;
    state_d = state_q;
    case (state_q)
      ST_SCAN: begin
        seen_d = seen_q | hit;
        if (&seen_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Clear the frame, but keep a commit landing in this very cycle
        seen_d  = hit;
        state_d = ST_SCAN;
      end
      default: begin
        seen_d  = '0;
        state_d = ST_SCAN;
      end
    endcase

    // A new error in the same cycle as a clear takes precedence
    err_d = clr_err_i ? ERR_NONE : err_q;
    if (an_multi)                       err_d = err_d | ERR_MULTI_AN;
    if (commit && !is_hex && !is_blank) err_d = err_d | ERR_GLYPH;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg_q <= '0;
      prev_sel_q <= '0;
      cnt_q      <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      seen_q     <= '0;
      err_q      <= ERR_NONE;
      state_q    <= ST_SCAN;
    end else begin
      if (an_one) begin
        prev_seg_q <= s_seg_q;
        prev_sel_q <= sel;
      end
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign digits_o      = digits_q;
  assign digit_valid_o = valid_q;
  assign frame_valid_o = (state_q == ST_DONE);
  assign err_code_o    = err_q;
  assign error_o       = |err_q;

endmodule : seg_scan_capture
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_capture
// Purpose  : Self-checking bench for seg_scan_capture (4 digits, 16-sample
//            dwell, active-low segments and anodes).
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        clr_err_i;
  logic [15:0] digits_o;
  logic [3:0]  digit_valid_o;
  logic        frame_valid_o;
  logic        error_o;
  logic [1:0]  err_code_o;

  int errors = 0;
  int checks = 0;
  int fcnt   = 0;
  int fbase  = 0;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          cyc;
    logic [15:0] dig;
    logic [3:0]  vld;
    logic [1:0]  err;
    int          frames;
  } vec_t;

  vec_t tbl[12];

  seg_scan_capture #(
    .NUM_DIGITS     (4),
    .STABLE_CYCLES  (16),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_in        (seg_in),
    .an_in         (an_in),
    .clr_err_i     (clr_err_i),
    .digits_o      (digits_o),
    .digit_valid_o (digit_valid_o),
    .frame_valid_o (frame_valid_o),
    .error_o       (error_o),
    .err_code_o    (err_code_o)
  );

  always #5 clk = ~clk;

  // Frame pulse counter, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_valid_o === 1'b1) fcnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    an_in  = an;
    seg_in = seg;
  endtask

  initial begin
    // Directed dwell table: {anodes, segments, cycles, digits, valid, err, frames}
    tbl[0]  = '{4'b1101, ~7'h4F, 32, 16'h0034, 4'h3, 2'b00, 0}; // '3' d1
    tbl[1]  = '{4'b1011, ~7'h5B, 32, 16'h0234, 4'h7, 2'b00, 0}; // '2' d2
    tbl[2]  = '{4'b0111, ~7'h06, 32, 16'h1234, 4'hF, 2'b00, 1}; // '1' d3, frame
    tbl[3]  = '{4'b1110, ~7'h66, 32, 16'h1234, 4'hF, 2'b00, 1};
    tbl[4]  = '{4'b1101, ~7'h4F, 32, 16'h1234, 4'hF, 2'b00, 1};
    tbl[5]  = '{4'b1011, ~7'h5B, 32, 16'h1234, 4'hF, 2'b00, 1};
    tbl[6]  = '{4'b0111, ~7'h06, 32, 16'h1234, 4'hF, 2'b00, 2}; // second frame
    tbl[7]  = '{4'b1011, ~7'h7F, 10, 16'h1234, 4'hF, 2'b00, 2}; // short '8' glitch
    tbl[8]  = '{4'b0111, ~7'h06, 32, 16'h1234, 4'hF, 2'b00, 2};
    tbl[9]  = '{4'b1111, 7'h7F,   8, 16'h1234, 4'hF, 2'b00, 2}; // blanking
    tbl[10] = '{4'b1110, 7'h7F,  32, 16'h1230, 4'hE, 2'b00, 2}; // blank glyph d0
    tbl[11] = '{4'b1110, ~7'h66, 32, 16'h1234, 4'hF, 2'b00, 2};

    // Reset with random inputs
    rst_n     = 1'b0;
    clr_err_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seg_in = 7'($urandom);
      an_in  = 4'($urandom);
      step(1);
    end
    chk("rst_digits", digits_o, 16'h0000);
    chk("rst_valid", digit_valid_o, 4'h0);
    chk("rst_frame", frame_valid_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_errcode", err_code_o, 2'b00);

    // Release into blanking, then first-commit latency on digit0 '4'
    drive(4'b1111, 7'h7F);
    step(1);
    rst_n = 1'b1;
    step(3);
    fbase = fcnt;
    drive(4'b1110, ~7'h66);
    step(16);
    chk("lat_before_digits", digits_o, 16'h0000);
    chk("lat_before_valid", digit_valid_o, 4'h0);
    step(1);
    chk("lat_at16_digits", digits_o, 16'h0004);
    chk("lat_at16_valid", digit_valid_o, 4'h1);
    step(15);

    // Table-driven dwells
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].an, tbl[i].seg);
      step(tbl[i].cyc);
      chk($sformatf("row%0d_digits", i), digits_o, tbl[i].dig);
      chk($sformatf("row%0d_valid", i), digit_valid_o, tbl[i].vld);
      chk($sformatf("row%0d_err", i), err_code_o, tbl[i].err);
      chk($sformatf("row%0d_frames", i), 32'(fcnt - fbase), 32'(tbl[i].frames));
    end

    // Unknown glyph on digit1, then clear
    drive(4'b1101, ~7'h7E);
    step(32);
    chk("unk_errcode", err_code_o, 2'b01);
    chk("unk_error", error_o, 1'b1);
    chk("unk_digits", digits_o, 16'h1234);
    chk("unk_frames", 32'(fcnt - fbase), 32'd2);
    drive(4'b1111, 7'h7F);
    clr_err_i = 1'b1;
    step(1);
    clr_err_i = 1'b0;
    step(1);
    chk("clr_error", error_o, 1'b0);
    chk("clr_errcode", err_code_o, 2'b00);

    // Anode overlap with a simultaneous clear: the new error must win
    drive(4'b1100, ~7'h5B);
    clr_err_i = 1'b1;
    step(3);
    chk("ovl_clr_race", error_o, 1'b1);
    clr_err_i = 1'b0;
    step(37);
    chk("ovl_errcode", err_code_o, 2'b10);
    chk("ovl_digits", digits_o, 16'h1234);
    chk("ovl_valid", digit_valid_o, 4'hF);
    chk("ovl_frames", 32'(fcnt - fbase), 32'd2);

    // Unknown glyph on top of the overlap error
    drive(4'b1101, ~7'h7E);
    step(32);
    chk("both_errcode", err_code_o, 2'b11);

    // Reset eight samples into a dwell of '7' on digit0
    drive(4'b1110, ~7'h07);
    step(8);
    rst_n = 1'b0;
    step(2);
    chk("mrst_digits", digits_o, 16'h0000);
    chk("mrst_valid", digit_valid_o, 4'h0);
    chk("mrst_error", error_o, 1'b0);
    rst_n = 1'b1;
    step(16);
    chk("mrst_before_digits", digits_o, 16'h0000);
    step(1);
    chk("mrst_at16_digits", digits_o, 16'h0007);
    chk("mrst_at16_valid", digit_valid_o, 4'h1);
    step(40);
    chk("mrst_hold_digits", digits_o, 16'h0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seg_scan_capture
`default_nettype wire

// File: doc/seg_scan_capture.md
# seg_scan_capture

Readback receiver for the multiplexed 7-segment display bus driven by the reaction-time top level. It samples the segment and anode lines and filters out ghosting at digit transitions. It decodes each stable segment pattern back to a 4-bit hex value and reports a complete frame once every digit has been captured. It sits beside the display driver, on the same on-chip segment/anode nets, for self-test and for scoring checks in the bench.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits / anode lines
- STABLE_CYCLES, 16, consecutive identical samples required before a digit is committed (2..255)
- SEG_ACTIVE_LOW, 1, segment lines are active-low when 1
- AN_ACTIVE_LOW, 1, anode lines are active-low when 1
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_in  in  7  segment lines, bit0=a … bit6=g
- an_in  in  NUM_DIGITS  anode lines, bit i selects digit i
- clr_err_i  in  1  synchronous clear of error_o and err_code_o
- digits_o  out  4*NUM_DIGITS  decoded values, digit i at [4i+3:4i]
- digit_valid_o  out  NUM_DIGITS  1 = digit i last committed a hex glyph; 0 = blank or never seen
- frame_valid_o  out  1  one-cycle pulse when all digits have been committed since the last pulse
- error_o  out  1  sticky error flag
- err_code_o  out  2  01 = unknown glyph, 10 = multiple anodes active, 11 = both seen

## Operation
- Inputs are registered once (s_seg, s_an), then normalised to active-high according to the polarity parameters.
- Anode decode of s_an:
  - Exactly one bit set: sel = index, and the sample is eligible.
  - Zero bits set: blanking interval, and the stability counter is cleared.
  - More than one bit set: err_code_o[1] is set, and the counter is cleared.
- Stability counter:
  - Clears to 1 whenever an eligible {sel, seg} differs from the previous eligible sample.
  - Increments by 1 while the sample is unchanged and saturates at STABLE_CYCLES.
  - A commit happens on the single cycle the counter becomes equal to STABLE_CYCLES. There is exactly one commit per dwell.
- Glyph decode, listed as value = gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71, blank=00.
- Commit actions:
  - Hex glyph: digits_o[sel] = value and digit_valid_o[sel] = 1.
  - Blank: digits_o[sel] = 0 and digit_valid_o[sel] = 0.
  - Unknown pattern: digit sel is unchanged, err_code_o[0] is set, and the digit's seen bit is not set.
- Frame FSM with states SCAN and DONE:
  - SCAN: each hex or blank commit sets seen[sel]. When seen is all ones, go to DONE.
  - DONE: frame_valid_o = 1 for exactly one cycle, seen is cleared, then return to SCAN.
  - A commit that occurs during DONE sets its seen bit after the clear, so it is not lost.
- error_o = |err_code_o.
- If clr_err_i and a new error occur in the same cycle, the new error wins and the flag stays set.

## Timing
- Reset (async assert, sync release) clears all outputs, seen, the counter and the sample registers to 0. The FSM goes to SCAN.
- Reset asserted mid-dwell or mid-frame aborts it immediately. No partial commit survives.
- Latency: a pattern presented before edge 0 is registered at edge 0, and digits_o updates at edge STABLE_CYCLES.
- frame_valid_o rises on the edge after the final commit.
- Dwells shorter than STABLE_CYCLES samples never commit.
- Holding a pattern indefinitely produces exactly one commit.
- The counter width is clog2(STABLE_CYCLES+1). It must saturate and never wrap.

## Structure
- Shared package seg_pkg holds:
  - the glyph constants (SEG_0 … SEG_F, SEG_BLANK)
  - the err_code localparams
  - the FSM state enum
- One sub-module, seg7_glyph_decode, is combinational. It takes 7 bits and produces {is_hex, is_blank, value[3:0]}, and is reused by the display driver's bench.

## Test plan
- Reset: hold rst_n=0 with random inputs. Require digits_o=0, digit_valid_o=0, frame_valid_o=0, error_o=0.
- Full frame: active-low anodes cycle digit0..3 showing '4','3','2','1' (seg_in = ~66, ~4F, ~5B, ~06), 32 cycles each. Require digits_o=16'h1234, digit_valid_o=4'hF, one frame_valid_o pulse per scan, and the first update exactly 16 cycles after the registered pattern.
- Glitch filter: 10-cycle dwell of '8' on digit2 between valid dwells. Require digit2 unchanged and no extra commit.
- Unknown glyph: stable seg=~7E on digit1. Require err_code_o=01, digit1 unchanged, and no frame_valid_o. Then pulse clr_err_i and require error_o=0.
- Anode overlap: an_in=4'b1100 (active-low, so digits 0 and 1 are both on) for 40 cycles. Require err_code_o=10 and no commit.
- Mid-dwell reset: assert rst_n=0 at cycle 8 of a dwell, release, then hold the pattern 16 cycles. Require the commit only at 16 cycles after release.
